regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port (WE3/A3/WD3) between N_SRC writeback

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a per-register busy
// scoreboard that flags RAW hazards on the two read addresses.
module regfile_wb_arbiter #(
  parameter int unsigned N_SRC     = 3,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned REG_WIDTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SRC-1:0]             src_valid,
  output logic [N_SRC-1:0]             src_ready,
  input  logic [N_SRC*5-1:0]           src_addr,
  input  logic [N_SRC*REG_WIDTH-1:0]   src_data,
  input  logic                         rsv_valid,
  input  logic [4:0]                   rsv_addr,
  output logic                         rsv_ready,
  input  logic [4:0]                   chk_a1,
  input  logic [4:0]                   chk_a2,
  output logic                         hazard,
  output logic                         we3,
  output logic [4:0]                   a3,
  output logic [REG_WIDTH-1:0]         wd3,
  output logic [NUM_REGS-1:0]          busy_vec
);

  localparam int unsigned PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned ADDR_W = 5;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic [N_SRC-1:0]     grant;
  logic                 found;
  logic                 xfer;
  logic [ADDR_W-1:0]    sel_addr;
  logic [REG_WIDTH-1:0] sel_data;
  logic                 sel_in_range;
  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  busy_next;
  logic                 rsv_busy;
  logic                 haz_a1;
  logic                 haz_a2;

  // First valid source at or after rr_ptr (modulo N_SRC) wins
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (!found && src_valid[i] && (((int'(rr_ptr) + k) % int'(N_SRC)) == i)) begin
          found      = 1'b1;
          grant[i]   = 1'b1;
          gnt_idx    = PTR_W'(i);
        end
      end
    end
    if (rst) begin
      grant = '0;
    end
  end

  assign src_ready = grant;
  assign xfer      = |grant;
  assign next_ptr  = (gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : PTR_W'(gnt_idx + PTR_W'(1));

  // Route the granted source onto the write port
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant[i]) begin
        sel_addr = src_addr[ADDR_W*i +: ADDR_W];
        sel_data = src_data[REG_WIDTH*i +: REG_WIDTH];
      end
    end
  end

  assign sel_in_range = 32'(sel_addr) < NUM_REGS;

  // Scoreboard lookups; addresses beyond NUM_REGS match no entry and read as idle
  always_comb begin
    rsv_busy = 1'b0;
    haz_a1   = 1'b0;
    haz_a2   = 1'b0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (rsv_addr == 5'(r)) rsv_busy = busy[r];
      if (chk_a1 == 5'(r))   haz_a1   = busy[r];
      if (chk_a2 == 5'(r))   haz_a2   = busy[r];
    end
  end

  assign rsv_ready = !rst && !rsv_busy && (32'(rsv_addr) < NUM_REGS);
  assign hazard    = haz_a1 | haz_a2;

  // Release by writeback first so a same-edge reservation of that register wins
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (xfer && sel_addr == 5'(r))                      busy_next[r] = 1'b0;
      if (rsv_valid && rsv_ready && rsv_addr == 5'(r))    busy_next[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3    <= 1'b0;
      a3     <= '0;
      wd3    <= '0;
      rr_ptr <= '0;
      busy   <= '0;
    end else begin
      we3  <= xfer && sel_in_range;
      busy <= busy_next;
      if (xfer) begin
        a3     <= sel_addr;
        wd3    <= sel_data;
        rr_ptr <= next_ptr;
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, reset-mid-write
// sequence, and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int NR = 8;
  localparam int W  = 256;

  logic             clk;
  logic             rst;
  logic [N-1:0]     src_valid;
  logic [N-1:0]     src_ready;
  logic [N*5-1:0]   src_addr;
  logic [N*W-1:0]   src_data;
  logic             rsv_valid;
  logic [4:0]       rsv_addr;
  logic             rsv_ready;
  logic [4:0]       chk_a1;
  logic [4:0]       chk_a2;
  logic             hazard;
  logic             we3;
  logic [4:0]       a3;
  logic [W-1:0]     wd3;
  logic [NR-1:0]    busy_vec;

  regfile_wb_arbiter #(.N_SRC(N), .NUM_REGS(NR), .REG_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(hazard),
    .we3(we3), .a3(a3), .wd3(wd3), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] sv;
    logic [4:0] addr;
    logic       rv;
    logic [4:0] ra;
    logic [4:0] c1;
    logic [2:0] rdy;
    logic       rsv_rdy;
    logic       haz;
    logic       we;
    logic [7:0] busy;
  } vec_t;

  vec_t tbl [15];
  logic [W-1:0] dconst [N];

  // Behavioural model state
  int         m_ptr;
  logic [7:0] m_busy;
  logic       m_we;
  logic [4:0] m_a3;
  logic [W-1:0] m_wd3;

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i = (ptr + k) % N;
      if (((v >> i) & 3'd1) != 3'd0) return i;
    end
    return -1;
  endfunction

  function automatic logic model_busy(input logic [7:0] b, input logic [4:0] a);
    if (int'(a) >= NR) return 1'b0;
    return b[a[2:0]];
  endfunction

  // Random-phase pending requests per source
  logic         pend  [N];
  logic [4:0]   paddr [N];
  logic [W-1:0] pdata [N];

  initial begin
    dconst[0] = W'(32'h1111);
    dconst[1] = W'(16'hABCD);
    dconst[2] = {8{32'hDEADBEEF}};

    //          sv      addr  rv    ra    c1     rdy     rr    hz    we    busy
    tbl[0]  = '{3'b111, 5'd1, 1'b0, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{3'b111, 5'd2, 1'b0, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{3'b111, 5'd3, 1'b0, 5'd0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{3'b111, 5'd4, 1'b0, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{3'b010, 5'd6, 1'b0, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{3'b010, 5'd7, 1'b0, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{3'b010, 5'd0, 1'b0, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{3'b000, 5'd0, 1'b1, 5'd5, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 8'h20};
    tbl[8]  = '{3'b000, 5'd0, 1'b0, 5'd5, 5'd5, 3'b000, 1'b0, 1'b1, 1'b0, 8'h20};
    tbl[9]  = '{3'b010, 5'd5, 1'b1, 5'd3, 5'd5, 3'b010, 1'b1, 1'b1, 1'b1, 8'h08};
    tbl[10] = '{3'b000, 5'd0, 1'b1, 5'd3, 5'd5, 3'b000, 1'b0, 1'b0, 1'b0, 8'h08};
    tbl[11] = '{3'b001, 5'd3, 1'b1, 5'd3, 5'd3, 3'b001, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[12] = '{3'b001, 5'd3, 1'b1, 5'd3, 5'd3, 3'b001, 1'b1, 1'b0, 1'b1, 8'h08};
    tbl[13] = '{3'b100, 5'd9, 1'b0, 5'd0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b0, 8'h08};
    tbl[14] = '{3'b000, 5'd0, 1'b1, 5'd9, 5'd9, 3'b000, 1'b0, 1'b0, 1'b0, 8'h08};

    // Reset with requests pending: grants and reservations must be blocked
    rst       = 1'b1;
    src_valid = 3'b111;
    src_addr  = '0;
    src_data  = {dconst[2], dconst[1], dconst[0]};
    rsv_valid = 1'b1;
    rsv_addr  = 5'd1;
    chk_a1    = 5'd0;
    chk_a2    = 5'd0;
    @(negedge clk);
    check("rst_src_ready", W'(src_ready), W'(0));
    check("rst_rsv_ready", W'(rsv_ready), W'(0));
    check("rst_we3", W'(we3), W'(0));
    check("rst_a3", W'(a3), W'(0));
    check("rst_wd3", wd3, W'(0));
    check("rst_busy", W'(busy_vec), W'(0));
    src_valid = '0;
    rsv_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table; state carries from row to row
    for (int r = 0; r < 15; r++) begin
      int g;
      @(negedge clk);
      src_valid = tbl[r].sv;
      src_addr  = {3{tbl[r].addr}};
      rsv_valid = tbl[r].rv;
      rsv_addr  = tbl[r].ra;
      chk_a1    = tbl[r].c1;
      chk_a2    = 5'd0;
      #1;
      check($sformatf("tbl%0d_src_ready", r), W'(src_ready), W'(tbl[r].rdy));
      check($sformatf("tbl%0d_rsv_ready", r), W'(rsv_ready), W'(tbl[r].rsv_rdy));
      check($sformatf("tbl%0d_hazard", r), W'(hazard), W'(tbl[r].haz));
      g = tbl[r].rdy[0] ? 0 : (tbl[r].rdy[1] ? 1 : 2);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_we3", r), W'(we3), W'(tbl[r].we));
      check($sformatf("tbl%0d_busy", r), W'(busy_vec), W'(tbl[r].busy));
      if (tbl[r].we) begin
        check($sformatf("tbl%0d_a3", r), W'(a3), W'(tbl[r].addr));
        check($sformatf("tbl%0d_wd3", r), wd3, dconst[g]);
      end
    end

    // Reset asserted while a write is on the port
    @(negedge clk);
    src_valid = 3'b111;
    src_addr  = {3{5'd2}};
    rsv_valid = 1'b1;
    rsv_addr  = 5'd6;
    chk_a1    = 5'd0;
    @(posedge clk);
    #1;
    check("mid_we3_before", W'(we3), W'(1));
    check("mid_busy_before", W'(busy_vec), W'(8'h48));
    #2;
    rst = 1'b1;
    #1;
    check("mid_we3_rst", W'(we3), W'(0));
    check("mid_busy_rst", W'(busy_vec), W'(0));
    check("mid_src_ready_rst", W'(src_ready), W'(0));
    check("mid_rsv_ready_rst", W'(rsv_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_first_grant", W'(src_ready), W'(3'b001));
    src_valid = '0;
    rsv_valid = 1'b0;

    // Randomized traffic vs model, starting from the just-reset state
    m_ptr  = 0;
    m_busy = '0;
    m_we   = 1'b0;
    m_a3   = '0;
    m_wd3  = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int g;
      logic       e_rsv_rdy;
      logic [N-1:0] e_rdy;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          paddr[i] = 5'($urandom_range(0, 9));
          pdata[i] = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        end
        src_valid[i]       = pend[i];
        src_addr[5*i +: 5] = paddr[i];
        src_data[W*i +: W] = pdata[i];
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 9));
      chk_a1    = 5'($urandom_range(0, 9));
      chk_a2    = 5'($urandom_range(0, 9));
      #1;
      g = model_grant(src_valid, m_ptr);
      e_rdy = '0;
      if (g >= 0) e_rdy = N'(1) << g;
      e_rsv_rdy = !model_busy(m_busy, rsv_addr) && int'(rsv_addr) < NR;
      check("rnd_src_ready", W'(src_ready), W'(e_rdy));
      check("rnd_rsv_ready", W'(rsv_ready), W'(e_rsv_rdy));
      check("rnd_hazard", W'(hazard),
            W'(model_busy(m_busy, chk_a1) | model_busy(m_busy, chk_a2)));
      @(posedge clk);
      m_we = 1'b0;
      if (g >= 0) begin
        if (int'(paddr[g]) < NR) begin
          m_we   = 1'b1;
          m_a3   = paddr[g];
          m_wd3  = pdata[g];
          m_busy = m_busy & ~(8'd1 << paddr[g]);
        end
        m_ptr   = (g + 1) % N;
        pend[g] = 1'b0;
      end
      if (rsv_valid && e_rsv_rdy) m_busy = m_busy | (8'd1 << rsv_addr);
      #1;
      check("rnd_we3", W'(we3), W'(m_we));
      check("rnd_busy", W'(busy_vec), W'(m_busy));
      if (m_we) begin
        check("rnd_a3", W'(a3), W'(m_a3));
        check("rnd_wd3", wd3, m_wd3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
